// File: rtl/game_score_ctrl.sv
// Game sequencing FSM and scoreboard feeding the VGA pixel generator: blank -> countdown -> play -> finish.
// Define GAME_SCORE_CTRL_SERVE_CD_EN to run a fresh countdown before every serve after a non-winning point.
module game_score_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int CNT_START = 3,
    parameter int WIN_SCORE = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       point0,
    input  logic       point1,
    output logic [2:0] state,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic [3:0] cnt0
);

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]      CNT_INIT  = 4'(CNT_START);
    localparam logic [3:0]      WIN       = 4'(WIN_SCORE);
    localparam logic [3:0]      SCORE_MAX = 4'd9;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_B_RST  = 3'd1,
        ST_B_PLAY = 3'd2,
        ST_PLAY   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      score0_d, score1_d, cnt0_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            tick;
    logic [3:0]      inc0, inc1;

    assign state = state_q;
    assign tick  = (state_q == ST_B_PLAY) && (presc_q == TICK_LAST);
    assign inc0  = (score0 == SCORE_MAX) ? SCORE_MAX : score0 + 4'd1;
    assign inc1  = (score1 == SCORE_MAX) ? SCORE_MAX : score1 + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
            score0  <= 4'd0;
            score1  <= 4'd0;
            cnt0    <= 4'd0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            score0  <= score0_d;
            score1  <= score1_d;
            cnt0    <= cnt0_d;
            presc_q <= presc_d;
        end
    end

    // Prescaler only runs while staying in B_PLAY, so every entry restarts a full second.
    always_comb begin
        state_d  = state_q;
        score0_d = score0;
        score1_d = score1;
        cnt0_d   = cnt0;
        presc_d  = '0;
        case (state_q)
            ST_RST: begin
                state_d  = ST_B_RST;
                score0_d = 4'd0;
                score1_d = 4'd0;
                cnt0_d   = 4'd0;
            end
            ST_B_RST: begin
                if (start) begin
                    state_d = ST_B_PLAY;
                    cnt0_d  = CNT_INIT;
                end
            end
            ST_B_PLAY: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    if (cnt0 != 4'd0) cnt0_d = cnt0 - 4'd1;
                    else              state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (point0 || point1) begin
                    if (point0) score0_d = inc0;
                    else        score1_d = inc1;
                    if ((point0 && inc0 == WIN) || (!point0 && inc1 == WIN)) begin
                        state_d = ST_FINISH;
                    end else begin
`ifdef GAME_SCORE_CTRL_SERVE_CD_EN
                        state_d = ST_B_PLAY;
                        cnt0_d  = CNT_INIT;
`else
                        state_d = ST_PLAY;
`endif
                    end
                end
            end
            ST_FINISH: begin
                if (start) begin
                    state_d  = ST_RST;
                    score0_d = 4'd0;
                    score1_d = 4'd0;
                    cnt0_d   = 4'd0;
                end
            end
            default: begin
                state_d  = ST_RST;
                score0_d = 4'd0;
                score1_d = 4'd0;
                cnt0_d   = 4'd0;
            end
        endcase
        // Abort overrides whatever the current state decided.
        if (abort) begin
            state_d  = ST_RST;
            score0_d = 4'd0;
            score1_d = 4'd0;
            cnt0_d   = 4'd0;
            presc_d  = '0;
        end
    end

endmodule

// File: tb/tb_game_score_ctrl.sv
// Self-checking bench for game_score_ctrl: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural game model.
module tb_game_score_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int CNT_START = 3;
    localparam int WIN_SCORE = 5;
`ifdef GAME_SCORE_CTRL_SERVE_CD_EN
    localparam bit SERVE_CD = 1'b1;
`else
    localparam bit SERVE_CD = 1'b0;
`endif

    localparam int M_RST = 0, M_BRST = 1, M_BPLAY = 2, M_PLAY = 3, M_FINISH = 4;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, point0, point1;
    logic [2:0] state;
    logic [3:0] score0, score1, cnt0;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    int m_state, m_s0, m_s1, m_cnt, m_k;
    int n_state, n_s0, n_s1, n_cnt, n_k;

    game_score_ctrl #(
        .TICK_DIV (TICK_DIV),
        .CNT_START(CNT_START),
        .WIN_SCORE(WIN_SCORE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .point0(point0),
        .point1(point1),
        .state (state),
        .score0(score0),
        .score1(score1),
        .cnt0  (cnt0)
    );

    always #5 clk = ~clk;

    // Game model: countdown expressed as elapsed cycles since entering B_PLAY.
    always_comb begin
        n_state = m_state;
        n_s0    = m_s0;
        n_s1    = m_s1;
        n_cnt   = m_cnt;
        n_k     = m_k;
        if (abort) begin
            n_state = M_RST; n_s0 = 0; n_s1 = 0; n_cnt = 0;
        end else begin
            case (m_state)
                M_RST: n_state = M_BRST;
                M_BRST: if (start) begin
                    n_state = M_BPLAY; n_cnt = CNT_START; n_k = 0;
                end
                M_BPLAY: begin
                    n_k = m_k + 1;
                    if (n_k == (CNT_START + 1) * TICK_DIV) begin
                        n_state = M_PLAY; n_cnt = 0;
                    end else begin
                        n_cnt = CNT_START - n_k / TICK_DIV;
                    end
                end
                M_PLAY: if (point0 || point1) begin
                    if (point0) n_s0 = (m_s0 < 9) ? m_s0 + 1 : 9;
                    else        n_s1 = (m_s1 < 9) ? m_s1 + 1 : 9;
                    if ((point0 ? n_s0 : n_s1) == WIN_SCORE) n_state = M_FINISH;
                    else if (SERVE_CD) begin
                        n_state = M_BPLAY; n_cnt = CNT_START; n_k = 0;
                    end
                end
                M_FINISH: if (start) begin
                    n_state = M_RST; n_s0 = 0; n_s1 = 0; n_cnt = 0;
                end
                default: n_state = M_RST;
            endcase
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= M_RST; m_s0 <= 0; m_s1 <= 0; m_cnt <= 0; m_k <= 0;
        end else begin
            m_state <= n_state; m_s0 <= n_s0; m_s1 <= n_s1; m_cnt <= n_cnt; m_k <= n_k;
        end
    end

    function automatic void check_val(input string name, input string field,
                                      input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=%0d expected=%0d at %0t", name, field, act, exp, $time);
        end
    endfunction

    task automatic checkOutput(input string name, input int es, input int e0, input int e1, input int ec);
        check_val(name, "state",  {29'd0, state},  es);
        check_val(name, "score0", {28'd0, score0}, e0);
        check_val(name, "score1", {28'd0, score1}, e1);
        check_val(name, "cnt0",   {28'd0, cnt0},   ec);
    endtask

    always @(negedge clk) begin
        if (cmp_en) checkOutput("model", m_state, m_s0, m_s1, m_cnt);
    end

    task automatic applyStimulus(input logic s, input logic a, input logic p0, input logic p1);
        start = s; abort = a; point0 = p0; point1 = p1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0; point0 = 1'b0; point1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; point0 = 1'b0; point1 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset", 0, 0, 0, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        idle(1);
        checkOutput("release", 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("brst_points", 1, 0, 0, 0);

        applyStimulus(1, 0, 0, 0);
        checkOutput("start", 2, 0, 0, 3);
        idle(3);  checkOutput("cnt3_end", 2, 0, 0, 3);
        idle(1);  checkOutput("cnt2", 2, 0, 0, 2);
        idle(4);  checkOutput("cnt1", 2, 0, 0, 1);
        idle(4);  checkOutput("cnt0", 2, 0, 0, 0);
        idle(3);  checkOutput("cnt0_end", 2, 0, 0, 0);
        idle(1);  checkOutput("play", 3, 0, 0, 0);

        if (SERVE_CD) begin
            applyStimulus(0, 0, 0, 1);
            checkOutput("cd_point1", 2, 0, 1, 3);
            idle(16);
            checkOutput("cd_replay", 3, 0, 1, 0);
            applyStimulus(0, 0, 1, 1);
            checkOutput("both_points", 2, 1, 1, 3);
            idle(16);
            for (int i = 2; i <= 4; i++) begin
                applyStimulus(0, 0, 1, 0);
                checkOutput("point0_run", 2, i, 1, 3);
                idle(16);
            end
        end else begin
            applyStimulus(0, 0, 1, 1);
            checkOutput("both_points", 3, 1, 0, 0);
            for (int i = 2; i <= 4; i++) begin
                applyStimulus(0, 0, 1, 0);
                checkOutput("point0_run", 3, i, 0, 0);
            end
        end
        applyStimulus(0, 0, 1, 0);
        checkOutput("win", 4, 5, SERVE_CD ? 1 : 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("finish_frozen", 4, 5, SERVE_CD ? 1 : 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("finish_start", 0, 0, 0, 0);
        idle(1);
        checkOutput("finish_brst", 1, 0, 0, 0);

        applyStimulus(1, 0, 0, 0);
        idle(5);
        checkOutput("mid_count", 2, 0, 0, 2);
        applyStimulus(0, 1, 0, 0);
        checkOutput("abort", 0, 0, 0, 0);
        idle(1);
        checkOutput("abort_brst", 1, 0, 0, 0);

        applyStimulus(1, 0, 0, 0);
        idle(16);
        applyStimulus(0, 0, 0, 1);
        checkOutput("play_point1", SERVE_CD ? 2 : 3, 0, 1, SERVE_CD ? 3 : 0);
        #1 rst_n = 1'b0;
        #1 checkOutput("async_reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        checkOutput("async_release", 1, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 149) == 0,
                              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            end
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
